// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: byte FIFO feeding a UART serialiser with runtime frame format (5-8 data, none/even/odd parity, 1/2 stop).
// Define UART_TX_BREAK_EN to add the brk_i line-break input.
module uart_tx_cfg #(
    parameter int DEPTH  = 32,
    parameter int BAUD_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [BAUD_W-1:0]      baud_div_i,
    input  logic                   tx_en_i,
    input  logic [1:0]             cfg_dbits_i,
    input  logic [1:0]             cfg_par_i,
    input  logic                   cfg_stop2_i,
    input  logic                   tx_we_i,
    input  logic [7:0]             din_i,
`ifdef UART_TX_BREAK_EN
    input  logic                   brk_i,
`endif
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   busy_o,
    output logic                   tx_bit_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic [7:0]        mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              push, pop;
    logic [7:0]        head, mask;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d, lim_m1;
    logic [2:0]        bit_q, bit_d, last_q, last_d;
    logic [7:0]        data_q, data_d;
    logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d, busy_q, busy_d, tx_q, tx_d;
    logic              run, tick, start_ok;

    assign full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign level_o  = wr_ptr_q - rd_ptr_q;
    assign push     = tx_we_i && !full_o;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign mask     = 8'hFF >> (2'd3 - cfg_dbits_i);
    assign lim_m1   = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
    assign busy_o   = busy_q;
    assign tx_bit_o = tx_q;

`ifdef UART_TX_BREAK_EN
    // gap_q counts the idle bit periods still owed after a break is released.
    logic [1:0] gap_q, gap_d;
    assign run      = busy_q || (gap_q != 2'd0);
    assign start_ok = tx_en_i && !empty_o && (gap_q == 2'd0) && !brk_i;
`else
    assign run      = busy_q;
    assign start_ok = tx_en_i && !empty_o;
`endif
    // Comparing with >= lets a divider shrunk mid-bit still terminate at the next count.
    assign tick = run && (cnt_q >= lim_m1);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = run ? (tick ? '0 : cnt_q + 1'b1) : '0;
        bit_d     = bit_q;
        last_d    = last_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        busy_d    = busy_q;
        pop       = 1'b0;
`ifdef UART_TX_BREAK_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (gap_q != 2'd0 && tick) gap_d = gap_q - 1'b1;
`endif
                if (start_ok) begin
                    state_d   = START;
                    pop       = 1'b1;
                    data_d    = head;
                    last_d    = {1'b0, cfg_dbits_i} + 3'd4;
                    par_en_d  = (cfg_par_i == 2'd1) || (cfg_par_i == 2'd2);
                    par_bit_d = (^(head & mask)) ^ (cfg_par_i == 2'd2);
                    stop2_d   = cfg_stop2_i;
                    bit_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                end
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                if (bit_q == last_q) begin
                    state_d = par_en_q ? PARITY : STOP;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                bit_d   = '0;
            end
            STOP: if (tick) begin
                if (stop2_q && bit_q == 3'd0) begin
                    bit_d = 3'd1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_BREAK_EN
        // A break aborts any frame; the popped byte is deliberately not restored.
        if (brk_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            pop     = 1'b0;
            cnt_d   = '0;
            gap_d   = 2'd2;
        end
`endif
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
`ifdef UART_TX_BREAK_EN
        if (brk_i) tx_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            last_q    <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
`ifdef UART_TX_BREAK_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            busy_q    <= busy_d;
            tx_q      <= tx_d;
`ifdef UART_TX_BREAK_EN
            gap_q     <= gap_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: randomized frame checks of uart_tx_cfg against a bit-level waveform model.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    localparam int DEPTH  = 32;
    localparam int BAUD_W = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [BAUD_W-1:0]      baud_div_i = '0;
    logic                   tx_en_i = 1'b0;
    logic [1:0]             cfg_dbits_i = '0;
    logic [1:0]             cfg_par_i = '0;
    logic                   cfg_stop2_i = 1'b0;
    logic                   tx_we_i = 1'b0;
    logic [7:0]             din_i = '0;
    logic                   full_o, empty_o, busy_o, tx_bit_o;
    logic [$clog2(DEPTH):0] level_o;
`ifdef UART_TX_BREAK_EN
    logic                   brk_i = 1'b0;
`endif

    uart_tx_cfg #(.DEPTH(DEPTH), .BAUD_W(BAUD_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div_i), .tx_en_i(tx_en_i),
        .cfg_dbits_i(cfg_dbits_i), .cfg_par_i(cfg_par_i), .cfg_stop2_i(cfg_stop2_i),
        .tx_we_i(tx_we_i), .din_i(din_i),
`ifdef UART_TX_BREAK_EN
        .brk_i(brk_i),
`endif
        .full_o(full_o), .empty_o(empty_o), .level_o(level_o), .busy_o(busy_o),
        .tx_bit_o(tx_bit_o)
    );

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic       exp_wave[$];
    logic       got_wave[$];
    int c_dbits, c_par, c_stop2, c_div;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the line level for every clock of one frame, derived from the frame rules.
    task automatic build_wave(input logic [7:0] b, input int dbits, input int par, input int stop2, input int div);
        int per, nb, ones;
        per  = (div == 0) ? 1 : div;
        nb   = 5 + dbits;
        ones = 0;
        exp_wave.delete();
        repeat (per) exp_wave.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            ones += int'(b[i]);
            repeat (per) exp_wave.push_back(b[i]);
        end
        if (par == 1 || par == 2) begin
            repeat (per) exp_wave.push_back(((ones % 2) == 1) ^ (par == 2));
        end
        repeat ((1 + stop2) * per) exp_wave.push_back(1'b1);
    endtask

    // driver tasks
    task automatic set_cfg();
        baud_div_i  = c_div[BAUD_W-1:0];
        cfg_dbits_i = c_dbits[1:0];
        cfg_par_i   = c_par[1:0];
        cfg_stop2_i = c_stop2[0];
    endtask

    task automatic write_byte(input logic [7:0] b);
        tx_we_i = 1'b1;
        din_i   = b;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        @(negedge clk);
        tx_we_i = 1'b0;
    endtask

    // mode 0: plain, 1: scramble cfg inputs mid-frame, 2: drop tx_en mid-frame
    task automatic capture_frame(input int mode, output int gap);
        int w, n, m, e0;
        logic [7:0] b;
        w = 0;
        while (!busy_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        gap = w;
        if (!busy_o) begin
            check_eq("start_timeout", 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", 32'd0, 32'd1);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        build_wave(b, c_dbits, c_par, c_stop2, c_div);
        got_wave.delete();
        n = 0;
        while (busy_o && n < 1000) begin
            got_wave.push_back(tx_bit_o);
            if (n == 3 && mode == 1) begin
                cfg_dbits_i = 2'($urandom);
                cfg_par_i   = 2'($urandom);
                cfg_stop2_i = 1'($urandom);
            end
            if (n == 3 && mode == 2) tx_en_i = 1'b0;
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("frame_len byte=%0h", b), n, exp_wave.size());
        m = (n < exp_wave.size()) ? n : exp_wave.size();
        for (int i = 0; i < m; i++) begin
            e0 = n_err;
            check_eq($sformatf("line byte=%0h cyc=%0d", b, i), got_wave[i], exp_wave[i]);
            if (n_err != e0) break;
        end
    endtask

    initial begin
        int gap, lows, busys;
        logic [7:0] b;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx_bit_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_empty", empty_o, 1);
        check_eq("rst_full", full_o, 0);
        check_eq("rst_level", level_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_tx", tx_bit_o, 1);

        // directed frames
        c_div = 4; c_dbits = 3; c_par = 0; c_stop2 = 0; set_cfg(); tx_en_i = 1'b1;
        write_byte(8'h55); capture_frame(0, gap);
        c_div = 2; c_dbits = 2; c_par = 1; c_stop2 = 1; set_cfg();
        write_byte(8'h83); capture_frame(0, gap);
        c_div = 3; c_dbits = 0; c_par = 2; c_stop2 = 0; set_cfg();
        write_byte(8'h1F); capture_frame(0, gap);
        c_div = 0; c_dbits = 1; c_par = 3; c_stop2 = 1; set_cfg();
        write_byte(8'hA6); capture_frame(0, gap);

        // random frames
        for (int k = 0; k < 24; k++) begin
            c_div = $urandom_range(0, 5); c_dbits = $urandom_range(0, 3);
            c_par = $urandom_range(0, 3); c_stop2 = $urandom_range(0, 1);
            set_cfg();
            write_byte(8'($urandom));
            capture_frame($urandom_range(0, 1), gap);
        end

        // tx_en dropped mid-frame: frame finishes, next one waits
        c_div = 2; c_dbits = 3; c_par = 1; c_stop2 = 0; set_cfg();
        tx_en_i = 1'b0;
        write_byte(8'($urandom)); write_byte(8'($urandom));
        check_eq("en_level2", level_o, 2);
        tx_en_i = 1'b1;
        capture_frame(2, gap);
        busys = 0;
        repeat (30) begin
            @(negedge clk);
            busys += int'(busy_o);
        end
        check_eq("en_off_no_start", busys, 0);
        check_eq("en_off_level", level_o, 1);
        tx_en_i = 1'b1;
        capture_frame(0, gap);

        // simultaneous write and pop
        c_div = 1; c_dbits = $urandom_range(0, 3); c_par = $urandom_range(0, 3); c_stop2 = 0; set_cfg();
        tx_en_i = 1'b0;
        write_byte(8'($urandom)); write_byte(8'($urandom));
        b = 8'($urandom);
        tx_en_i = 1'b1;
        write_byte(b);
        check_eq("wr_pop_level", level_o, 2);
        check_eq("wr_pop_busy", busy_o, 1);
        for (int k = 0; k < 3; k++) begin
            capture_frame(0, gap);
            if (k > 0) check_eq($sformatf("wr_pop_gap%0d", k), gap, 1);
        end

        // fill to full, overflow, then drain back-to-back
        c_div = 1; c_dbits = 3; c_par = 0; c_stop2 = 0; set_cfg();
        tx_en_i = 1'b0;
        for (int k = 0; k < DEPTH; k++) write_byte(8'($urandom));
        check_eq("full_flag", full_o, 1);
        check_eq("full_level", level_o, DEPTH);
        write_byte(8'($urandom));
        check_eq("ovf_level", level_o, DEPTH);
        check_eq("ovf_full", full_o, 1);
        tx_en_i = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            capture_frame(0, gap);
            if (k > 0) check_eq($sformatf("b2b_gap%0d", k), gap, 1);
        end
        repeat (3) @(negedge clk);
        check_eq("drain_empty", empty_o, 1);
        check_eq("drain_busy", busy_o, 0);
        check_eq("drain_level", level_o, 0);
        check_eq("drain_model", exp_q.size(), 0);

        // reset during DATA
        c_div = 4; c_dbits = 3; c_par = 0; c_stop2 = 0; set_cfg();
        write_byte(8'h00); write_byte(8'h11); write_byte(8'h22);
        repeat (14) @(negedge clk);
        check_eq("pre_rst_busy", busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", tx_bit_o, 1);
        check_eq("mid_rst_level", level_o, 0);
        check_eq("mid_rst_empty", empty_o, 1);
        check_eq("mid_rst_busy", busy_o, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0; busys = 0;
        repeat (40) begin
            @(negedge clk);
            lows  += int'(!tx_bit_o);
            busys += int'(busy_o);
        end
        check_eq("post_rst_line_low", lows, 0);
        check_eq("post_rst_busy", busys, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
